// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default widths and FSM state encoding.
package icache_pkg;

    localparam int ICACHE_ADDR_W  = 32;
    localparam int ICACHE_INDEX_W = 7;
    localparam int INST_W         = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

endpackage

// File: rtl/icache_mem.sv
// Line storage for the direct-mapped instruction cache.
// It has one combinational read port and one synchronous write port.
module icache_mem
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_ADDR_W - ICACHE_INDEX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [INST_W-1:0]  o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [INST_W-1:0]  i_wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [INST_W-1:0] r_data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
    // qualify a line, so these arrays stay mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    // Reads see the contents as they stood before this cycle's write.
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int ADDR_W  = ICACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_ok,
    output logic [INST_W-1:0] if_inst,
    output logic              inst_fe,
    output logic [ADDR_W-1:0] inst_fpc,
    input  logic              inst_ok,
    input  logic [INST_W-1:0] inst_o,
    input  logic [ADDR_W-1:0] inst_pc
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    state_t            r_state;
    logic              r_if_ok;
    logic [INST_W-1:0] r_if_inst;
    logic              r_inst_fe;
    logic [ADDR_W-1:0] r_inst_fpc;

    logic [ADDR_W-1:0]  w_req_pc;
    logic [INDEX_W-1:0] w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [INST_W-1:0]  w_rd_data;
    logic               w_hit;
    logic               w_fill;
    logic               w_lookup_hit;
    logic               w_lookup_miss;

    assign w_req_pc  = if_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    assign w_req_idx = w_req_pc[INDEX_W+1:2];
    assign w_req_tag = w_req_pc[ADDR_W-1:INDEX_W+2];
    assign w_hit     = w_rd_valid && (w_rd_tag == w_req_tag);

    // Fills are accepted only while a fetch is outstanding, so a response to a
    // request abandoned by reset is dropped.
    assign w_fill        = rdy && inst_ok && r_inst_fe;
    assign w_lookup_hit  = rdy && (r_state == ST_IDLE) && if_req && w_hit;
    assign w_lookup_miss = rdy && (r_state == ST_IDLE) && if_req && !w_hit;

    icache_mem #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_req_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_idx   (inst_pc[INDEX_W+1:2]),
        .i_wr_tag   (inst_pc[ADDR_W-1:INDEX_W+2]),
        .i_wr_data  (inst_o)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_if_ok    <= 1'b0;
            r_if_inst  <= '0;
            r_inst_fe  <= 1'b0;
            r_inst_fpc <= '0;
        end else if (rdy) begin
            r_if_ok <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_req) begin
                        if (w_hit) begin
                            r_if_ok   <= 1'b1;
                            r_if_inst <= w_rd_data;
                        end else begin
                            r_inst_fe  <= 1'b1;
                            r_inst_fpc <= w_req_pc;
                            r_state    <= ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (!if_req) begin
                        r_inst_fe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (inst_ok && (inst_pc == r_inst_fpc)) begin
                        r_if_ok   <= 1'b1;
                        r_if_inst <= inst_o;
                        r_inst_fe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_req_pc != r_inst_fpc) begin
                        // Branch redirect while the fetch is outstanding.
                        r_inst_fpc <= w_req_pc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_ok    = r_if_ok;
    assign if_inst  = r_if_inst;
    assign inst_fe  = r_inst_fe;
    assign inst_fpc = r_inst_fpc;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lookup_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_lookup_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized fetches
// checked against a line-level model of a direct-mapped cache.
module tb_icache;

    localparam int LINES = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_ok;
    logic [31:0] if_inst;
    logic        inst_fe;
    logic [31:0] inst_fpc;
    logic        inst_ok;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_req   (if_req),
        .if_pc    (if_pc),
        .if_ok    (if_ok),
        .if_inst  (if_inst),
        .inst_fe  (inst_fe),
        .inst_fpc (inst_fpc),
        .inst_ok  (inst_ok),
        .inst_o   (inst_o),
        .inst_pc  (inst_pc)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    // Reference model: which word address each line holds, and its data.
    bit          m_valid [LINES];
    logic [31:0] m_word  [LINES];
    logic [31:0] m_data  [LINES];
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a / 4) % LINES;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_word[line_of(a)] == a / 4);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a / 4;
        return w * 32'h9E37_79B1 + 32'h0000_1357;
    endfunction

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        m_valid[line_of(a)] = 1'b1;
        m_word[line_of(a)]  = a / 4;
        m_data[line_of(a)]  = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " if_ok"}, if_ok, 0);
        check({tag, " if_inst"}, if_inst, 0);
        check({tag, " inst_fe"}, inst_fe, 0);
        check({tag, " inst_fpc"}, inst_fpc, 0);
    endtask

    // Fetch expected to miss, answered by mem_ctrl after `delay` idle cycles.
    task automatic miss_fill(input string tag, input logic [31:0] pc, input logic [31:0] data,
                             input int delay);
        logic [31:0] al;
        al = pc & 32'hFFFF_FFFC;
        if_req = 1'b1;
        if_pc  = pc;
        step();
        exp_misses++;
        check({tag, " miss fe"}, inst_fe, 1);
        check({tag, " miss fpc"}, inst_fpc, al);
        check({tag, " miss no ok"}, if_ok, 0);
        for (int i = 0; i < delay; i++) begin
            step();
            check({tag, " wait fe"}, inst_fe, 1);
            check({tag, " wait no ok"}, if_ok, 0);
        end
        inst_ok = 1'b1;
        inst_pc = al;
        inst_o  = data;
        step();
        inst_ok = 1'b0;
        model_fill(al, data);
        check({tag, " fill ok"}, if_ok, 1);
        check({tag, " fill inst"}, if_inst, data);
        check({tag, " fill fe"}, inst_fe, 0);
        if_req = 1'b0;
        step();
        check({tag, " ok pulse"}, if_ok, 0);
    endtask

    // Fetch expected to hit; data comes from the model.
    task automatic hit_fetch(input string tag, input logic [31:0] pc);
        if_req = 1'b1;
        if_pc  = pc;
        step();
        exp_hits++;
        check({tag, " hit ok"}, if_ok, 1);
        check({tag, " hit inst"}, if_inst, m_data[line_of(pc)]);
        check({tag, " hit fe"}, inst_fe, 0);
        if_req = 1'b0;
        step();
        check({tag, " hit pulse"}, if_ok, 0);
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, " hit_cnt"}, hit_cnt, exp_hits);
        check({tag, " miss_cnt"}, miss_cnt, exp_misses);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        logic [31:0] pc;

        // Reset
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_pc = '0;
        inst_ok = 1'b0; inst_o = '0; inst_pc = '0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("post-reset");
        check_counters("post-reset");

        // First fetch of 0x100 misses and is filled with 0x00000013
        miss_fill("first", 32'h100, 32'h0000_0013, 0);

        // Refetch hits with single-cycle latency
        hit_fetch("refetch", 32'h100);
        check_counters("refetch");

        // Redirect during a miss, stale fill, then matching fill
        if_req = 1'b1; if_pc = 32'h200;
        step();
        exp_misses++;
        check("redir fe", inst_fe, 1);
        check("redir fpc0", inst_fpc, 32'h200);
        if_pc = 32'h300;
        step();
        check("redir fpc1", inst_fpc, 32'h300);
        check("redir fe1", inst_fe, 1);
        inst_ok = 1'b1; inst_pc = 32'h200; inst_o = 32'hAAAA_0200;
        step();
        model_fill(32'h200, 32'hAAAA_0200);
        check("stale no ok", if_ok, 0);
        check("stale fe", inst_fe, 1);
        check("stale fpc", inst_fpc, 32'h300);
        inst_pc = 32'h300; inst_o = 32'hBBBB_0300;
        step();
        inst_ok = 1'b0;
        model_fill(32'h300, 32'hBBBB_0300);
        check("redir ok", if_ok, 1);
        check("redir inst", if_inst, 32'hBBBB_0300);
        check("redir fe done", inst_fe, 0);
        if_req = 1'b0;
        step();
        hit_fetch("stale line", 32'h200);

        // Same-index addresses evict each other
        for (int i = 0; i < 6; i++) begin
            pc = (i % 2 == 0) ? 32'h004 : 32'h204;
            miss_fill($sformatf("conflict%0d", i), pc, mem_word(pc) ^ i, 0);
        end

        // rdy low freezes a miss even while inputs wander
        if_req = 1'b1; if_pc = 32'h400;
        step();
        exp_misses++;
        check("stall fe0", inst_fe, 1);
        rdy = 1'b0; if_req = 1'b0; if_pc = 32'h500;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall fe%0d", i + 1), inst_fe, 1);
            check($sformatf("stall fpc%0d", i + 1), inst_fpc, 32'h400);
            check($sformatf("stall ok%0d", i + 1), if_ok, 0);
        end
        rdy = 1'b1; if_req = 1'b1; if_pc = 32'h400;
        inst_ok = 1'b1; inst_pc = 32'h400; inst_o = 32'hCCCC_0400;
        step();
        inst_ok = 1'b0;
        model_fill(32'h400, 32'hCCCC_0400);
        check("stall resume ok", if_ok, 1);
        check("stall resume inst", if_inst, 32'hCCCC_0400);
        if_req = 1'b0;
        step();
        check_counters("pre-abort");

        // Reset mid-miss abandons the fill
        if_req = 1'b1; if_pc = 32'h600;
        step();
        check("abort fe", inst_fe, 1);
        rst = 1'b1;
        #2;
        model_reset();
        check_reset_outputs("abort reset");
        if_req = 1'b0;
        step();
        rst = 1'b0;
        inst_ok = 1'b1; inst_pc = 32'h600; inst_o = 32'hDDDD_0600;
        step();
        inst_ok = 1'b0;
        check("late ok ignored", if_ok, 0);
        check("late fe", inst_fe, 0);
        check_counters("abort");
        miss_fill("invalid 0x100", 32'h100, 32'h0000_0013, 1);
        miss_fill("invalid 0x600", 32'h600, 32'hDDDD_0601, 0);
        miss_fill("invalid 0x300", 32'h300, 32'hBBBB_0300, 0);

        // Randomized fetches against the model
        for (int t = 0; t < 60; t++) begin
            pc = $urandom_range(0, 3) * 32'h200 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
            if (model_hit(pc)) begin
                hit_fetch($sformatf("rnd%0d", t), pc);
            end else begin
                miss_fill($sformatf("rnd%0d", t), pc, mem_word(pc) + t, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                step();
                check($sformatf("rnd%0d idle", t), if_ok, 0);
            end
        end
        check_counters("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
